mux16_rr_arbiter: RTL
=====================

MUX16_RR_ARBITER -- requirements
Module: mux16_rr_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the number of cycles a grant may wait for out_ready before it is revoked (legal range 1..255).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port enable  input  1  permits new arbitration when high.
REQ-005 SHALL have port req  input  16  per-channel request; bit i is requester i.
REQ-006 SHALL have port out_ready  input  1  downstream accepts the granted channel this cycle.
REQ-007 SHALL have port sel  output  4  registered select driving the sel input of the 16:1 mux; encodes the granted channel.
REQ-008 SHALL have port grant  output  16  registered one-hot grant; all zero when no grant.
REQ-009 SHALL have port out_valid  output  1  a grant is active and sel is meaningful.
REQ-010 SHALL have port timeout  output  1  single-cycle pulse when a grant is revoked by TIMEOUT.

Function
REQ-011 SHALL implement an FSM with two states: IDLE and GRANT.
REQ-012 In IDLE, with enable=1 and req!=0, SHALL pick the first requester at or after ptr, searching upward with wrap 15->0, and enter GRANT.
REQ-013 On that transition SHALL load sel=picked index and grant=1<<index, and assert out_valid; the latency is 1 cycle from sampled req to out_valid.
REQ-014 In IDLE with enable=0 or req==0, SHALL remain in IDLE with out_valid=0, grant=0, and sel holding its last value.
REQ-015 In GRANT, sel and grant SHALL be stable until the state is left.
REQ-016 In GRANT, out_valid&out_ready SHALL complete the grant: set ptr=(sel+1) mod 16 (15 wraps to 0), go to IDLE, and drive out_valid=0 the next cycle.
REQ-017 In GRANT, if req[sel] falls with out_ready=0, SHALL withdraw: go to IDLE with ptr unchanged and no timeout pulse.
REQ-018 In GRANT, SHALL run an 8-bit wait counter that clears on entry and increments each cycle without acceptance.
REQ-019 When the wait counter equals TIMEOUT-1 with no acceptance, SHALL revoke the grant: pulse timeout for 1 cycle, set ptr=(sel+1) mod 16, and go to IDLE.
REQ-020 When events coincide in the same cycle, priority SHALL be: acceptance > withdraw > timeout.
REQ-021 enable falling during GRANT SHALL NOT affect the active grant.
REQ-022 Maximum throughput SHALL be one grant per 2 cycles, since IDLE always costs one bubble cycle.
REQ-023 grant SHALL always equal the one-hot decode of sel whenever out_valid=1.
REQ-024 Every continuously requesting channel SHALL be granted within 16 completed or revoked grants (starvation-free).

Reset
REQ-025 rst=1 SHALL, at the next clk edge, set: state=IDLE, ptr=0, sel=0, grant=0, out_valid=0, timeout=0, wait counter=0.
REQ-026 rst asserted during GRANT SHALL abort the grant without a timeout pulse; rst SHALL take priority over every other event.

Structure
REQ-027 Package mux16_arb_pkg SHALL hold NUM_CH=16, SEL_W=4, and the state enum (IDLE, GRANT).
REQ-028 A combinational sub-module rr_pick16 SHALL take inputs req[15:0] and ptr[3:0], and produce outputs idx[3:0] and found.
REQ-029 sel SHALL connect directly to a 16:1 mux instance; the arbiter SHALL contain no datapath.

Verification
REQ-030 Reset then req=16'h0001, enable=1 -> out_valid=1 and sel=0 one cycle later; out_ready=1 -> out_valid=0 next cycle, ptr=1.
REQ-031 req=16'hFFFF held, out_ready=1 constantly -> sel sequence 0,1,2,...,15,0 with one grant every 2 cycles.
REQ-032 ptr=15, req=16'h8001 -> sel=15 granted first, then sel=0 (wrap).
REQ-033 TIMEOUT=4, req=16'h0010, out_ready=0 -> timeout pulses 4 cycles after out_valid rose; next grant to channel 4 only after the pointer wraps.
REQ-034 Grant on channel 3; req[3] falls and out_ready=1 in the same cycle -> acceptance counted, ptr=4, timeout=0.
REQ-035 rst=1 mid-GRANT on sel=7 -> next cycle out_valid=0, grant=0, sel=0, timeout=0; first post-reset grant searches from 0.

Source files
------------

// File: rtl/mux16_arb_pkg.sv
// Shared constants and types for the 16-channel round-robin arbiter.
package mux16_arb_pkg;

    localparam int unsigned NUM_CH = 16;
    localparam int unsigned SEL_W  = 4;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_e;

    function automatic logic [NUM_CH-1:0] onehot16(input logic [SEL_W-1:0] s);
        return NUM_CH'(1) << s;
    endfunction

endpackage

// File: rtl/rr_pick16.sv
// Combinational round-robin picker: first set bit of req at or above ptr, wrapping 15->0.
module rr_pick16
    import mux16_arb_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  idx,
    output logic              found
);

    logic [2*NUM_CH-1:0] req_dbl;
    logic [NUM_CH-1:0]   req_rot;
    logic [SEL_W-1:0]    offset;

    always_comb begin
        // Rotate so that bit 0 of req_rot is channel ptr; the doubled copy supplies the wrap.
        req_dbl = {req, req};
        req_rot = NUM_CH'(req_dbl >> ptr);
        offset  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = SEL_W'(i);
            end
        end
        idx   = ptr + offset;
        found = |req;
    end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter producing a registered select for an external 16:1 mux,
// with withdraw on request drop and revocation after TIMEOUT cycles without acceptance.
module mux16_rr_arbiter
    import mux16_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NUM_CH-1:0] req,
    input  logic              out_ready,
    output logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] grant,
    output logic              out_valid,
    output logic              timeout
);

    localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

    arb_state_e       state;
    logic [SEL_W-1:0] ptr;
    logic [7:0]       wait_cnt;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;

    rr_pick16 u_pick (
        .req   (req),
        .ptr   (ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            sel       <= '0;
            grant     <= '0;
            out_valid <= 1'b0;
            timeout   <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && pick_found) begin
                        state     <= GRANT;
                        sel       <= pick_idx;
                        grant     <= onehot16(pick_idx);
                        out_valid <= 1'b1;
                        wait_cnt  <= '0;
                    end else begin
                        out_valid <= 1'b0;
                        grant     <= '0;
                    end
                end
                GRANT: begin
                    // Acceptance beats withdraw, which beats timeout.
                    if (out_ready) begin
                        state     <= IDLE;
                        ptr       <= sel + SEL_W'(1);
                        out_valid <= 1'b0;
                        grant     <= '0;
                    end else if (!req[sel]) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        grant     <= '0;
                    end else if (wait_cnt == WaitLast) begin
                        state     <= IDLE;
                        ptr       <= sel + SEL_W'(1);
                        out_valid <= 1'b0;
                        grant     <= '0;
                        timeout   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule
